// File: rtl/ring_buffer_sched_pkg.sv
// -----------------------------------------------------------------------------
// accel_buf_pkg
// Shared types for the ring buffer scheduler of the convolution accelerator.
//   DATA_OF_SET : data words per buffer entry
//   DATA_WIDTH  : bits per data word
//   entry_t     : one buffer entry, DATA_OF_SET words of DATA_WIDTH bits
//   rd_state_t  : read burst sequencer states
// -----------------------------------------------------------------------------
package accel_buf_pkg;

  localparam int DATA_OF_SET = 4;
  localparam int DATA_WIDTH  = 8;

  typedef logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ring_buffer_sched_if.sv
// -----------------------------------------------------------------------------
// ring_buffer_sched_if
// Bundles every non-clock signal of the scheduler.
//   slave  : the scheduler side (ring_buffer_sched)
//   master : the environment side (producers, ring buffer, PE array control)
// Signals:
//   req_valid/req_data/req_ready : NUM_REQ write producers, one-hot grant
//   buf_wen/buf_din/buf_full     : ring buffer write port
//   buf_ren/buf_empty/buf_dout   : ring buffer read port (dout one cycle late)
//   rd_start/rd_len/rd_busy/rd_done : read burst control
//   out_valid/out_data           : registered read data to the PE array
// -----------------------------------------------------------------------------
interface ring_buffer_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 8
) ();
  import accel_buf_pkg::*;

  logic [NUM_REQ-1:0]   req_valid;
  entry_t [NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  logic                 buf_wen;
  entry_t               buf_din;
  logic                 buf_full;
  logic                 buf_ren;
  logic                 buf_empty;
  entry_t               buf_dout;

  logic                 rd_start;
  logic [LEN_W-1:0]     rd_len;
  logic                 rd_busy;
  logic                 rd_done;

  logic                 out_valid;
  entry_t               out_data;

  modport slave (
    input  req_valid, req_data, buf_full, buf_empty, buf_dout, rd_start, rd_len,
    output req_ready, buf_wen, buf_din, buf_ren, rd_busy, rd_done, out_valid, out_data
  );

  modport master (
    output req_valid, req_data, buf_full, buf_empty, buf_dout, rd_start, rd_len,
    input  req_ready, buf_wen, buf_din, buf_ren, rd_busy, rd_done, out_valid, out_data
  );

endinterface

// File: rtl/ring_buffer_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a combinational one-hot grant and a registered
// priority pointer.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, pointer returns to 0
//   i_req   : request vector
//   i_en    : grant enable; with i_en=0 no grant is issued and ptr holds
//   o_grant : one-hot grant, first requester at or above ptr (wrapping)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;
  logic [PTR_W-1:0] w_gnt_idx;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W:0]   w_sum;
  logic             w_any;

  // Walk the requesters starting at ptr. The sum is one bit wider than the
  // pointer so ptr+k can exceed NUM_REQ-1 before it is wrapped back.
  always_comb begin
    o_grant   = '0;
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (i_en && !w_any && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_any          = 1'b1;
        w_gnt_idx      = w_idx;
      end
    end
  end

  // The winner drops to lowest priority for the next round.
  assign w_ptr_next = (w_gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/ring_buffer_sched.sv
// -----------------------------------------------------------------------------
// ring_buffer_sched
// Scheduler around one ring_buffer instance: shares the single write port
// between NUM_REQ producers (round robin), sequences read bursts of rd_len
// entries into the PE array and re-registers the read data with a strobe.
//   clk : clock, rising edge
//   rst : synchronous active-high reset; aborts a burst without rd_done and
//         drops any read data still in flight
//   bus : ring_buffer_sched_if.slave, see the interface for the signal list
// Read data latency: buf_ren in cycle T -> buf_dout in T+1 -> out_valid in T+2.
// -----------------------------------------------------------------------------
module ring_buffer_sched
  import accel_buf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 8
) (
  input logic                clk,
  input logic                rst,
  ring_buffer_sched_if.slave bus
);

  // ---------------- write arbitration ----------------
  logic [NUM_REQ-1:0]   w_grant;
  entry_t [NUM_REQ-1:0] w_masked;
  entry_t               w_din;

  // Holding reset keeps every output quiet, including the combinational grant.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (bus.req_valid),
    .i_en    (~bus.buf_full & ~rst),
    .o_grant (w_grant)
  );

  // AND-OR write data mux: the grant is one-hot, so OR of masked payloads
  // selects the winner and yields zero when nobody is granted.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_din_mask
    assign w_masked[gi] = w_grant[gi] ? bus.req_data[gi] : '0;
  end

  always_comb begin
    w_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_din = w_din | w_masked[i];
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.buf_wen   = |w_grant;
  assign bus.buf_din   = w_din;

  // ---------------- read burst FSM ----------------
  rd_state_t        r_state;
  rd_state_t        w_state_next;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_next;
  logic             r_zero_done;
  logic             w_zero_done_next;
  logic             w_ren;
  logic             w_done;
  logic             w_busy;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_zero_done_next = 1'b0;
    w_ren            = 1'b0;
    w_done           = r_zero_done;
    w_busy           = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.rd_start) begin
          if (bus.rd_len != '0) begin
            w_cnt_next   = bus.rd_len;
            w_state_next = READ;
          end else begin
            // Empty burst still acknowledges, one cycle later.
            w_zero_done_next = 1'b1;
          end
        end
      end
      READ: begin
        w_busy = 1'b1;
        // An empty buffer stalls the burst with the count held.
        w_ren  = ~bus.buf_empty;
        if (w_ren) begin
          w_cnt_next = r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) begin
            w_state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Last entry is on buf_dout during this cycle.
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (rst) begin
      w_ren  = 1'b0;
      w_done = 1'b0;
      w_busy = 1'b0;
    end
  end

  // ---------------- state and read data registers ----------------
  logic   r_ren_d;
  logic   r_out_valid;
  entry_t r_out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_zero_done <= 1'b0;
      r_ren_d     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_zero_done <= w_zero_done_next;
      r_ren_d     <= w_ren;
      r_out_valid <= r_ren_d;
      if (r_ren_d) begin
        r_out_data <= bus.buf_dout;
      end
    end
  end

  assign bus.buf_ren   = w_ren;
  assign bus.rd_busy   = w_busy;
  assign bus.rd_done   = w_done;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_ring_buffer_sched.sv
// -----------------------------------------------------------------------------
// tb_ring_buffer_sched
// Drives ring_buffer_sched with directed scenarios followed by random traffic.
// A behavioural ring buffer (a queue) and a reference of the scheduling rules
// predict every control output each cycle; read data is predicted into a
// scoreboard queue that a separate monitor drains whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_ring_buffer_sched;
  import accel_buf_pkg::*;

  localparam int NR    = 2;
  localparam int LW    = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ring_buffer_sched_if #(.NUM_REQ(NR), .LEN_W(LW)) bus ();

  ring_buffer_sched #(.NUM_REQ(NR), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    entry_t d;
    int     due;
  } exp_t;

  int     vectors    = 0;
  int     miscompares = 0;
  int     cyc        = 0;

  // environment / reference state
  entry_t mq[$];          // ring buffer contents, oldest first
  exp_t   exp_q[$];       // predicted out_data with the cycle it must appear
  bit     p_pend[NR];
  entry_t p_data[NR];
  int     prod_mode;      // 0: no new requests, 1: always, 2: random
  bit     force_full;
  bit     rst_now;
  bit     start_now;
  logic [LW-1:0] len_now;
  int     m_ptr;
  bit     m_busy;
  bit     m_flush;
  bit     m_zero;
  int     m_rem;
  bit     dout_ok;
  entry_t dout_val;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, check, advance the reference.
  task automatic step();
    int g;
    int idx;
    bit er, ed, eb, was_busy;
    logic [NR-1:0] eg;
    logic [NR-1:0] pv;
    entry_t popped;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (rst_now) begin
        p_pend[i] = 1'b0;
      end else if (!p_pend[i] && (prod_mode == 1 || (prod_mode == 2 && $urandom_range(0, 2) == 0))) begin
        p_pend[i] = 1'b1;
        p_data[i] = entry_t'($urandom);
      end
    end
    pv = '0;
    for (int i = 0; i < NR; i++) begin
      if (p_pend[i]) pv = pv | (NR'(1) << i);
      bus.req_data[i] = p_data[i];
    end
    rst           = rst_now;
    bus.req_valid = pv;
    bus.buf_full  = (mq.size() >= DEPTH) || force_full;
    bus.buf_empty = (mq.size() == 0);
    bus.buf_dout  = dout_ok ? dout_val : entry_t'($urandom);
    bus.rd_start  = start_now;
    bus.rd_len    = len_now;

    // reference: first pending producer at or after the pointer, modulo NR
    g = -1;
    if (!rst_now && !bus.buf_full) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (g < 0 && p_pend[idx]) g = idx;
      end
    end
    eg = (g >= 0) ? (NR'(1) << g) : '0;
    er = !rst_now && m_busy && !m_flush && (mq.size() != 0);
    ed = !rst_now && (m_flush || m_zero);
    eb = !rst_now && m_busy;

    @(negedge clk);
    #1;
    chk("req_ready", 64'(bus.req_ready), 64'(eg));
    chk("buf_wen", 64'(bus.buf_wen), 64'(g >= 0));
    if (g >= 0) chk("buf_din", 64'(bus.buf_din), 64'(p_data[g]));
    chk("buf_ren", 64'(bus.buf_ren), 64'(er));
    chk("rd_done", 64'(bus.rd_done), 64'(ed));
    chk("rd_busy", 64'(bus.rd_busy), 64'(eb));

    dout_ok = 1'b0;
    if (rst_now) begin
      mq.delete();
      exp_q.delete();
      m_ptr   = 0;
      m_busy  = 1'b0;
      m_flush = 1'b0;
      m_zero  = 1'b0;
      m_rem   = 0;
    end else begin
      was_busy = m_busy;
      if (er) begin
        popped = mq.pop_front();
        exp_q.push_back('{popped, cyc + 2});
        dout_ok  = 1'b1;
        dout_val = popped;
      end
      if (g >= 0) begin
        mq.push_back(p_data[g]);
        $display("wr  cyc=%0d req=%0d data=%h", cyc, g, p_data[g]);
        p_pend[g] = 1'b0;
        m_ptr = (g + 1) % NR;
      end
      m_zero = 1'b0;
      if (m_flush) begin
        m_flush = 1'b0;
        m_busy  = 1'b0;
      end else if (er) begin
        m_rem--;
        if (m_rem == 0) m_flush = 1'b1;
      end
      if (!was_busy && start_now) begin
        if (len_now != '0) begin
          m_busy = 1'b1;
          m_rem  = int'(len_now);
        end else begin
          m_zero = 1'b1;
        end
      end
    end
    start_now = 1'b0;
  endtask

  task automatic start_burst(input int len);
    start_now = 1'b1;
    len_now   = LW'(len);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (bus.rd_done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s got=no rd_done want=rd_done within 100 cycles", name);
    end
  endtask

  // Monitor: compare read data whenever the DUT presents it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL out_valid cyc=%0d got=1 want=0 (nothing outstanding)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e.d));
          chk("out_latency", 64'(cyc), 64'(e.due));
          $display("rd  cyc=%0d data=%h", cyc, bus.out_data);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL out_valid cyc=%0d got=0 want=1 data=%h", cyc, e.d);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.buf_full  = 1'b0;
    bus.buf_empty = 1'b1;
    bus.buf_dout  = '0;
    bus.rd_start  = 1'b0;
    bus.rd_len    = '0;
    for (int i = 0; i < NR; i++) begin
      p_pend[i] = 1'b0;
      p_data[i] = '0;
    end
    prod_mode  = 0;
    force_full = 1'b0;
    rst_now    = 1'b1;
    start_now  = 1'b0;
    len_now    = '0;
    m_ptr = 0; m_busy = 1'b0; m_flush = 1'b0; m_zero = 1'b0; m_rem = 0;
    dout_ok = 1'b0; dout_val = '0;

    // reset
    repeat (3) step();
    rst_now = 1'b0;
    step();
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_data", 64'(bus.out_data), 64'd0);

    // single writer
    p_pend[0] = 1'b1;
    p_data[0] = 32'h01020304;
    step();
    chk("single_din", 64'(bus.buf_din), 64'h01020304);

    // contention: both producers keep requesting for 4 cycles
    prod_mode = 1;
    repeat (4) step();
    prod_mode = 0;

    // full: grants blocked, then resume at the saved pointer
    p_pend[0] = 1'b1; p_data[0] = entry_t'($urandom);
    p_pend[1] = 1'b1; p_data[1] = entry_t'($urandom);
    force_full = 1'b1;
    repeat (2) step();
    force_full = 1'b0;
    repeat (3) step();

    // drain everything written so far
    start_burst(mq.size());
    wait_done("drain");
    step();

    // burst of 3 from an empty buffer
    for (int i = 0; i < 3; i++) begin
      p_pend[i % NR] = 1'b1;
      p_data[i % NR] = entry_t'(32'hA0B0C000 + i);
      step();
    end
    start_burst(3);
    wait_done("burst3");
    step();

    // starved burst: 2 requested, 1 available
    p_pend[0] = 1'b1; p_data[0] = entry_t'(32'h11111111);
    step();
    start_burst(2);
    repeat (5) step();
    chk("starved_busy", 64'(bus.rd_busy), 64'd1);
    p_pend[1] = 1'b1; p_data[1] = entry_t'(32'h22222222);
    wait_done("starved");
    step();

    // zero-length burst
    start_burst(0);
    step();
    step();
    chk("zero_len_done", 64'(bus.rd_done), 64'd1);
    step();

    // reset in the middle of a burst
    for (int i = 0; i < 4; i++) begin
      p_pend[0] = 1'b1; p_data[0] = entry_t'($urandom);
      step();
    end
    start_burst(4);
    repeat (2) step();
    rst_now = 1'b1;
    step();
    rst_now = 1'b0;
    step();
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_busy", 64'(bus.rd_busy), 64'd0);
    chk("midrst_done", 64'(bus.rd_done), 64'd0);
    chk("midrst_ren", 64'(bus.buf_ren), 64'd0);

    // random traffic
    prod_mode = 2;
    for (int n = 0; n < 1500; n++) begin
      force_full = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) start_burst($urandom_range(0, 6));
      rst_now = ($urandom_range(0, 399) == 0);
      step();
      rst_now = 1'b0;
    end

    // let any open burst finish and outstanding data come out
    prod_mode  = 2;
    force_full = 1'b0;
    for (int n = 0; n < 300 && m_busy; n++) step();
    prod_mode = 0;
    repeat (6) step();
    chk("idle_at_end", 64'(m_busy), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
